// File: rtl/lsu_pkg.sv
// Shared LSU definitions: ld_st_sel encodings, arbiter FSM states and the sub-word store merge.
package lsu_pkg;

   localparam logic [2:0] SEL_B  = 3'b000;
   localparam logic [2:0] SEL_H  = 3'b001;
   localparam logic [2:0] SEL_W  = 3'b010;
   localparam logic [2:0] SEL_BU = 3'b100;
   localparam logic [2:0] SEL_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RMW_RD,
      ST_RMW_WR
   } arb_state_t;

   function automatic logic sel_illegal(input logic we, input logic [2:0] sel);
      if (we) return sel[2] || (sel == 3'b011);
      return (sel == 3'b011) || (sel[2:1] == 2'b11);
   endfunction

   // Replace one byte (sb) or one half (sh) of a read word; lane[0] is ignored for halves.
   function automatic logic [31:0] merge_sub(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [2:0] sel, input logic [1:0] lane);
      logic [31:0] m;
      m = word;
      if (sel == SEL_H) begin
         if (lane[1]) m[31:16] = wdata[15:0];
         else         m[15:0]  = wdata[15:0];
      end else begin
         case (lane)
            2'd0:    m[7:0]   = wdata[7:0];
            2'd1:    m[15:8]  = wdata[7:0];
            2'd2:    m[23:16] = wdata[7:0];
            default: m[31:24] = wdata[7:0];
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter, round-robin or fixed m0 priority; remembers which side won last.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       fixed_prio,
   output logic [1:0] gnt
);

   logic last_grant_q, last_grant_d;   // 1 = m1 won the previous grant

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = (fixed_prio || last_grant_q) ? 2'b01 : 2'b10;
      last_grant_d = last_grant_q;
      if (update && (gnt != 2'b00)) last_grant_d = gnt[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for the LSU data port: arbitrates, sequences one access per grant,
// turns sb/sh into read-word + merged-word-write, and returns registered load data with a done pulse.
module dmem_arbiter
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter bit M0_PRIORITY = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_sel,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_sel,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] lsu_addr_o,
   output logic [DATA_W-1:0] lsu_st_data_o,
   output logic              lsu_st_en_o,
   output logic [2:0]        lsu_sel_o,
   input  logic [DATA_W-1:0] lsu_ld_data_i,
   output logic              busy_o
);

   arb_state_t        state_q, state_d;
   logic              id_q, id_d, we_q, we_d;
   logic [1:0]        lane_q, lane_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        sel_q, sel_d;
   logic [ADDR_W-1:0] lsu_addr_q, lsu_addr_d;
   logic [DATA_W-1:0] lsu_st_data_q, lsu_st_data_d;
   logic              lsu_st_en_q, lsu_st_en_d;
   logic [2:0]        lsu_sel_q, lsu_sel_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [1:0]        done_q, done_d, err_q, err_d;

   logic              idle;
   logic [1:0]        gnt;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [2:0]        req_sel;

   assign idle = (state_q == ST_IDLE);

   rr_arb2 u_arb (
      .clk        (clk),
      .reset      (reset),
      .req        ({m1_req, m0_req} & {2{idle}}),
      .update     (idle),
      .fixed_prio (M0_PRIORITY),
      .gnt        (gnt)
   );

   assign req_we    = gnt[1] ? m1_we    : m0_we;
   assign req_addr  = gnt[1] ? m1_addr  : m0_addr;
   assign req_wdata = gnt[1] ? m1_wdata : m0_wdata;
   assign req_sel   = gnt[1] ? m1_sel   : m0_sel;

   // LSU outputs are registered, so each state computes what the LSU sees in the next state.
   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      we_d          = we_q;
      lane_d        = lane_q;
      wdata_d       = wdata_q;
      sel_d         = sel_q;
      lsu_addr_d    = lsu_addr_q;
      lsu_st_data_d = lsu_st_data_q;
      lsu_st_en_d   = 1'b0;
      lsu_sel_d     = SEL_W;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      done_d        = 2'b00;
      err_d         = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               id_d    = gnt[1];
               we_d    = req_we;
               lane_d  = req_addr[1:0];
               wdata_d = req_wdata;
               sel_d   = req_sel;
               if (sel_illegal(req_we, req_sel)) begin
                  done_d = gnt;
                  err_d  = gnt;
               end else if (req_we && (req_sel != SEL_W)) begin
                  state_d    = ST_RMW_RD;
                  lsu_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
               end else begin
                  state_d    = ST_ACCESS;
                  lsu_addr_d = req_addr;
                  if (req_we) begin
                     lsu_st_data_d = req_wdata;
                     lsu_st_en_d   = 1'b1;
                  end else begin
                     lsu_sel_d = req_sel;
                  end
               end
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               if (id_q) rdata1_d = lsu_ld_data_i;
               else      rdata0_d = lsu_ld_data_i;
            end
            done_d  = id_q ? 2'b10 : 2'b01;
            state_d = ST_IDLE;
         end
         ST_RMW_RD: begin
            lsu_st_data_d = merge_sub(lsu_ld_data_i, wdata_q, sel_q, lane_q);
            lsu_st_en_d   = 1'b1;
            state_d       = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            done_d  = id_q ? 2'b10 : 2'b01;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         id_q          <= 1'b0;
         we_q          <= 1'b0;
         lane_q        <= 2'b00;
         wdata_q       <= '0;
         sel_q         <= SEL_W;
         lsu_addr_q    <= '0;
         lsu_st_data_q <= '0;
         lsu_st_en_q   <= 1'b0;
         lsu_sel_q     <= SEL_W;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         done_q        <= 2'b00;
         err_q         <= 2'b00;
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         we_q          <= we_d;
         lane_q        <= lane_d;
         wdata_q       <= wdata_d;
         sel_q         <= sel_d;
         lsu_addr_q    <= lsu_addr_d;
         lsu_st_data_q <= lsu_st_data_d;
         lsu_st_en_q   <= lsu_st_en_d;
         lsu_sel_q     <= lsu_sel_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign m0_gnt        = gnt[0];
   assign m1_gnt        = gnt[1];
   assign m0_done       = done_q[0];
   assign m1_done       = done_q[1];
   assign m0_err        = err_q[0];
   assign m1_err        = err_q[1];
   assign m0_rdata      = rdata0_q;
   assign m1_rdata      = rdata1_q;
   assign lsu_addr_o    = lsu_addr_q;
   assign lsu_st_data_o = lsu_st_data_q;
   assign lsu_st_en_o   = lsu_st_en_q;
   assign lsu_sel_o     = lsu_sel_q;
   assign busy_o        = !idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural LSU memory plus a request/completion scoreboard.
module tb_dmem_arbiter;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
   logic [11:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic [2:0]  m0_sel;
   logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
   logic [11:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [2:0]  m1_sel;
   logic [11:0] lsu_addr;
   logic [31:0] lsu_st_data, lsu_ld_data;
   logic        lsu_st_en, busy;
   logic [2:0]  lsu_sel;

   // second instance, fixed priority, only its grants are observed
   logic        p0_req, p1_req, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, p_st_en, p_busy;
   logic [31:0] p0_rdata, p1_rdata, p_st_data;
   logic [11:0] p_addr;
   logic [2:0]  p_sel;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .M0_PRIORITY(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .lsu_addr_o(lsu_addr), .lsu_st_data_o(lsu_st_data), .lsu_st_en_o(lsu_st_en),
      .lsu_sel_o(lsu_sel), .lsu_ld_data_i(lsu_ld_data), .busy_o(busy)
   );

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .M0_PRIORITY(1'b1)) u_dut_fp (
      .clk(clk), .reset(reset),
      .m0_req(p0_req), .m0_we(1'b0), .m0_addr(12'h000), .m0_wdata(32'h0), .m0_sel(SEL_W),
      .m0_gnt(p0_gnt), .m0_done(p0_done), .m0_rdata(p0_rdata), .m0_err(p0_err),
      .m1_req(p1_req), .m1_we(1'b0), .m1_addr(12'h004), .m1_wdata(32'h0), .m1_sel(SEL_W),
      .m1_gnt(p1_gnt), .m1_done(p1_done), .m1_rdata(p1_rdata), .m1_err(p1_err),
      .lsu_addr_o(p_addr), .lsu_st_data_o(p_st_data), .lsu_st_en_o(p_st_en),
      .lsu_sel_o(p_sel), .lsu_ld_data_i(32'h0), .busy_o(p_busy)
   );

   typedef struct {
      bit          id;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [2:0]  sel;
      int          gcyc;
   } txn_t;

   logic [31:0] mem     [0:1023];
   logic [31:0] exp_mem [0:1023];
   logic [31:0] exp_rd  [0:1];
   logic [31:0] last_wr;
   txn_t        sb_q[$];
   int          gnt_order[$];
   int          gnt_cyc[$];
   int          cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, n_st = 0;
   int          p_cnt0 = 0, p_cnt1 = 0;
   bit          p_cnt_en = 1'b0;

   function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] sel);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * a));
      h = a[1] ? w[31:16] : w[15:0];
      case (sel)
         SEL_B:   return {{24{b[7]}}, b};
         SEL_BU:  return {24'h0, b};
         SEL_H:   return {{16{h[15]}}, h};
         SEL_HU:  return {16'h0, h};
         SEL_W:   return w;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] a, input logic [2:0] sel);
      logic [31:0] mask, data;
      case (sel)
         SEL_B: begin
            mask = 32'hFF << (8 * a);
            data = {4{d[7:0]}};
         end
         SEL_H: begin
            mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            data = {2{d[15:0]}};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = d;
         end
      endcase
      return (w & ~mask) | (data & mask);
   endfunction

   function automatic bit is_illegal(input logic we, input logic [2:0] sel);
      if (we) return !(sel inside {SEL_B, SEL_H, SEL_W});
      return !(sel inside {SEL_B, SEL_H, SEL_W, SEL_BU, SEL_HU});
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behavioural LSU: combinational load extraction, word store on the clock edge.
   assign lsu_ld_data = ld_ext(mem[lsu_addr[11:2]], lsu_addr[1:0], lsu_sel);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (lsu_st_en) begin
         mem[lsu_addr[11:2]] <= lsu_st_data;
         last_wr <= lsu_st_data;
      end
   end

   task automatic sb_push(input bit id);
      txn_t t;
      check("gnt_idle", 32'(busy), 32'd0);
      check("gnt_onehot", 32'(m0_gnt && m1_gnt), 32'd0);
      t.id    = id;
      t.we    = id ? m1_we    : m0_we;
      t.addr  = id ? m1_addr  : m0_addr;
      t.wdata = id ? m1_wdata : m0_wdata;
      t.sel   = id ? m1_sel   : m0_sel;
      t.gcyc  = cyc;
      sb_q.push_back(t);
      gnt_order.push_back(int'(id));
      gnt_cyc.push_back(cyc);
   endtask

   task automatic sb_pop(input bit id);
      txn_t t;
      bit   ill;
      int   lat;
      n_done++;
      if (sb_q.size() == 0) begin
         check("spurious_done", 32'd1, 32'd0);
         return;
      end
      t   = sb_q.pop_front();
      ill = is_illegal(t.we, t.sel);
      lat = ill ? 1 : ((t.we && t.sel != SEL_W) ? 3 : 2);
      check("done_id", 32'(id), 32'(t.id));
      check("done_lat", 32'(cyc - t.gcyc), 32'(lat));
      check("done_err", 32'(id ? m1_err : m0_err), 32'(ill));
      if (!ill) begin
         if (t.we) exp_mem[t.addr[11:2]] = st_merge(exp_mem[t.addr[11:2]], t.wdata, t.addr[1:0], t.sel);
         else      exp_rd[t.id] = ld_ext(exp_mem[t.addr[11:2]], t.addr[1:0], t.sel);
      end
      check("done_rdata", id ? m1_rdata : m0_rdata, exp_rd[t.id]);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (m0_done || m1_done) begin
            check("done_onehot", 32'(m0_done && m1_done), 32'd0);
            sb_pop(m1_done);
         end
         if (m0_gnt || m1_gnt) sb_push(m1_gnt);
         if (lsu_st_en) begin
            n_st++;
            check("st_sel", 32'(lsu_sel), 32'(SEL_W));
         end
         if (p_cnt_en) begin
            p_cnt0 += int'(p0_gnt);
            p_cnt1 += int'(p1_gnt);
         end
      end
   end

   // Present one request on port id and return just after its accept edge.
   task automatic do_op(input bit id, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [2:0] sel, input bit keep);
      bit got = 1'b0;
      if (id) begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel;
      end else begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel;
      end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = id ? m1_gnt : m0_gnt;
      end
      if (!got) check("gnt_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!keep) begin
         if (id) m1_req = 1'b0;
         else    m0_req = 1'b0;
      end
   endtask

   task automatic wait_quiet();
      int i = 0;
      while (sb_q.size() != 0 && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (sb_q.size() != 0) check("done_timeout", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          st0, d0;
      logic [31:0] old;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = SEL_W;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = SEL_W;
      p0_req = 0; p1_req = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      mem[4]  = 32'hDEAD_BEEF;
      mem[12] = 32'h8001_0080;
      for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sel", 32'(lsu_sel), 32'(SEL_W));
      check("rst_st_en", 32'(lsu_st_en), 32'd0);
      check("rst_addr", 32'(lsu_addr), 32'd0);
      check("rst_st_data", lsu_st_data, 32'd0);
      check("rst_flags", 32'({busy, m0_done, m1_done, m0_err, m1_err, m0_gnt, m1_gnt}), 32'd0);
      check("rst_rdata0", m0_rdata, 32'd0);
      check("rst_rdata1", m1_rdata, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // word load, m0 alone
      st0 = n_st;
      do_op(0, 1'b0, 12'h010, 32'h0, SEL_W, 1'b0);
      wait_quiet();
      check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("t1_no_st", 32'(n_st - st0), 32'd0);

      // byte and half stores via read-modify-write
      mem[4] = 32'h1122_3344;
      exp_mem[4] = 32'h1122_3344;
      st0 = n_st;
      do_op(1, 1'b1, 12'h013, 32'h0000_00AA, SEL_B, 1'b0);
      wait_quiet();
      check("t2_mem", mem[4], 32'hAA22_3344);
      check("t2_wr_cnt", 32'(n_st - st0), 32'd1);
      check("t2_wr_dat", last_wr, 32'hAA22_3344);
      old = mem[5];
      do_op(0, 1'b1, 12'h017, 32'h1234_CAFE, SEL_H, 1'b0);
      wait_quiet();
      check("t2_sh_mem", mem[5], {16'hCAFE, old[15:0]});
      do_op(1, 1'b1, 12'h019, 32'hFFFF_FF77, SEL_B, 1'b0);
      wait_quiet();
      do_op(0, 1'b0, 12'h018, 32'h0, SEL_W, 1'b0);
      wait_quiet();
      do_op(1, 1'b1, 12'h020, 32'h0BAD_F00D, SEL_W, 1'b0);
      wait_quiet();
      do_op(0, 1'b0, 12'h020, 32'h0, SEL_W, 1'b0);
      wait_quiet();
      check("t2_sw_rd", m0_rdata, 32'h0BAD_F00D);

      // sign and zero extension
      do_op(1, 1'b0, 12'h030, 32'h0, SEL_B, 1'b0);
      wait_quiet();
      check("t4_lb", m1_rdata, 32'hFFFF_FF80);
      do_op(0, 1'b0, 12'h030, 32'h0, SEL_BU, 1'b0);
      wait_quiet();
      check("t4_lbu", m0_rdata, 32'h0000_0080);
      do_op(1, 1'b0, 12'h032, 32'h0, SEL_H, 1'b0);
      wait_quiet();
      check("t4_lh", m1_rdata, 32'hFFFF_8001);
      do_op(0, 1'b0, 12'h032, 32'h0, SEL_HU, 1'b0);
      wait_quiet();
      check("t4_lhu", m0_rdata, 32'h0000_8001);

      // illegal selects
      st0 = n_st;
      old = mem[4];
      do_op(0, 1'b1, 12'h010, 32'h1234_5678, 3'b100, 1'b0);
      wait_quiet();
      do_op(1, 1'b0, 12'h010, 32'h0, 3'b011, 1'b0);
      wait_quiet();
      check("t5_no_st", 32'(n_st - st0), 32'd0);
      check("t5_mem", mem[4], old);
      check("t5_rdata0", m0_rdata, 32'h0000_8001);

      // reset during the read half of an sb
      old = mem[16];
      d0  = n_done;
      do_op(1, 1'b1, 12'h041, 32'h0000_0055, SEL_B, 1'b0);
      #2 reset = 1'b1;
      sb_q.delete();
      #1;
      check("t6_st_en", 32'(lsu_st_en), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      repeat (4) @(negedge clk);
      check("t6_no_done", 32'(n_done - d0), 32'd0);
      check("t6_mem", mem[16], old);
      check("t6_rdata1", m1_rdata, 32'd0);
      @(posedge clk);
      #1;

      // contention: first tie after reset goes to m0, then alternation
      gnt_order.delete();
      gnt_cyc.delete();
      p0_req = 1'b1;
      p1_req = 1'b1;
      p_cnt_en = 1'b1;
      fork
         begin
            do_op(0, 1'b0, 12'h010, 32'h0, SEL_W, 1'b1);
            do_op(0, 1'b0, 12'h014, 32'h0, SEL_W, 1'b0);
         end
         begin
            do_op(1, 1'b0, 12'h020, 32'h0, SEL_W, 1'b1);
            do_op(1, 1'b0, 12'h030, 32'h0, SEL_B, 1'b0);
         end
      join
      wait_quiet();
      p_cnt_en = 1'b0;
      p0_req = 1'b0;
      p1_req = 1'b0;
      check("t3_ngnt", 32'(gnt_order.size()), 32'd4);
      for (int i = 0; i < gnt_order.size(); i++)
         check($sformatf("t3_order%0d", i), 32'(gnt_order[i]), 32'(i % 2));
      for (int i = 1; i < gnt_cyc.size(); i++)
         check($sformatf("t3_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
      check("t3_fp_m1", 32'(p_cnt1), 32'd0);
      check("t3_fp_m0", 32'(p_cnt0 >= 3), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
